// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bits needed to count 0..w-1 iterations (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/neg_cond.sv
// Conditional two's-complement negate.
// Ports:
//   mag_i   - value in
//   neg_i   - 1 = negate, 0 = pass through
//   res_c_o - combinational result (-mag_i or mag_i)
module neg_cond #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] mag_i,
  input  logic         neg_i,
  output logic [W-1:0] res_c_o
);

  // Negating the most negative value wraps to itself, which is exactly its
  // unsigned magnitude, so no overflow handling is needed.
  assign res_c_o = neg_i ? (~mag_i + W'(1)) : mag_i;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one iteration per clock, WIDTH iterations.
// Signed operands are reduced to magnitudes on Start, multiplied unsigned and
// the product is negated in FIX when the result sign is set.
// Ports:
//   Clock, Reset (async, active-low)
//   Start, Signed, Multiplicand, Multiplier - request and operands
//   Abort  - cancel an operation in RUN/FIX
//   Hi, Lo - last completed product (registered)
//   Busy   - high in RUN and FIX
//   Done   - one-cycle completion pulse
module mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [PW-1:0]      prod;
  logic [WIDTH:0]     sum;

  // Operand magnitudes and signed product.
  neg_cond #(.W(WIDTH)) u_neg_a (
    .mag_i   (Multiplicand),
    .neg_i   (Signed & Multiplicand[WIDTH-1]),
    .res_c_o (mag_a)
  );

  neg_cond #(.W(WIDTH)) u_neg_b (
    .mag_i   (Multiplier),
    .neg_i   (Signed & Multiplier[WIDTH-1]),
    .res_c_o (mag_b)
  );

  neg_cond #(.W(PW)) u_neg_p (
    .mag_i   (acc_q),
    .neg_i   (sign_q),
    .res_c_o (prod)
  );

  // Upper half plus conditional addend, carry kept in the extra bit.
  assign sum = {1'b0, acc_q[PW-1:WIDTH]}
             + (acc_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          mcand_d = mag_a;
          acc_d   = {WIDTH'(0), mag_b};
          sign_d  = Signed & (Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1]);
          cnt_d   = CW'(0);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      RUN: begin
        if (Abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!Abort) begin
          hi_d    = prod[PW-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= CW'(0);
      acc_q   <= PW'(0);
      mcand_q <= WIDTH'(0);
      sign_q  <= 1'b0;
      hi_q    <= WIDTH'(0);
      lo_q    <= WIDTH'(0);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed self-checking bench for mult_seq at WIDTH=32.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic         Clock;
  logic         Reset;
  logic         Start;
  logic         Signed;
  logic         Abort;
  logic [W-1:0] Multiplicand;
  logic [W-1:0] Multiplier;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;
  logic         Busy;
  logic         Done;

  int checks;
  int failures;
  int n;
  int dcnt;

  mult_seq #(.WIDTH(W)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Signed       (Signed),
    .Abort        (Abort),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Hi           (Hi),
    .Lo           (Lo),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for exactly one sampling edge.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    Signed       = sgn;
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    tick();
    Start        = 1'b0;
  endtask

  // Edges until Done is seen, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!Done && cnt < 60);
  endtask

  initial begin
    checks = 0; failures = 0;
    Reset = 1'b0; Start = 1'b0; Signed = 1'b0; Abort = 1'b0;
    Multiplicand = '0; Multiplier = '0;

    // Reset state
    tick(); tick();
    chk("rst_hi", 64'(Hi), 64'h0);
    chk("rst_lo", 64'(Lo), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    Reset = 1'b1;
    tick();

    // 7 x 6 unsigned with latency
    start_op(1'b0, 32'd7, 32'd6);
    chk("u76_busy", 64'(Busy), 64'h1);
    wait_done(n);
    chk("u76_lat", 64'(n), 64'd33);
    chk("u76_hi", 64'(Hi), 64'h0);
    chk("u76_lo", 64'(Lo), 64'h2A);
    chk("u76_busy_done", 64'(Busy), 64'h0);
    tick();
    chk("u76_done_pulse", 64'(Done), 64'h0);

    // -3 x 5 signed; previous result held during RUN
    start_op(1'b1, 32'hFFFF_FFFD, 32'd5);
    repeat (5) tick();
    chk("hold_lo_run", 64'(Lo), 64'h2A);
    wait_done(n);
    chk("s35_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("s35_lo", 64'(Lo), 64'hFFFF_FFF1);

    // most negative squared
    tick();
    start_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    chk("smin_hi", 64'(Hi), 64'h4000_0000);
    chk("smin_lo", 64'(Lo), 64'h0);

    // all-ones unsigned and signed
    tick();
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("uff_hi", 64'(Hi), 64'hFFFF_FFFE);
    chk("uff_lo", 64'(Lo), 64'h1);
    tick();
    start_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    chk("sff_hi", 64'(Hi), 64'h0);
    chk("sff_lo", 64'(Lo), 64'h1);

    // Start ignored in RUN, then back-to-back Start in DONE
    tick();
    start_op(1'b0, 32'd2, 32'd3);
    repeat (5) tick();
    start_op(1'b0, 32'd9, 32'd9);
    wait_done(n);
    chk("ign_lat", 64'(n), 64'd27);
    chk("ign_lo", 64'(Lo), 64'd6);
    start_op(1'b0, 32'd9, 32'd9);
    chk("b2b_busy", 64'(Busy), 64'h1);
    chk("b2b_done", 64'(Done), 64'h0);
    wait_done(n);
    chk("b2b_lat", 64'(n), 64'd33);
    chk("b2b_lo", 64'(Lo), 64'd81);

    // Abort at iteration 10 after a result of 42
    tick();
    start_op(1'b0, 32'd7, 32'd6);
    wait_done(n);
    chk("pre_abort_lo", 64'(Lo), 64'h2A);
    tick();
    start_op(1'b0, 32'd5, 32'd5);
    repeat (10) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_busy", 64'(Busy), 64'h0);
    dcnt = 0;
    repeat (40) begin
      if (Done) dcnt++;
      tick();
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_hi", 64'(Hi), 64'h0);
    chk("abort_lo", 64'(Lo), 64'h2A);

    // Reset at iteration 20, then a fresh 4 x 4
    start_op(1'b0, 32'd3, 32'd3);
    repeat (20) tick();
    Reset = 1'b0;
    #1;
    chk("mrst_hi", 64'(Hi), 64'h0);
    chk("mrst_lo", 64'(Lo), 64'h0);
    chk("mrst_busy", 64'(Busy), 64'h0);
    tick(); tick();
    Reset = 1'b1;
    dcnt = 0;
    repeat (40) begin
      if (Done || Busy) dcnt++;
      tick();
    end
    chk("mrst_idle", 64'(dcnt), 64'd0);
    start_op(1'b0, 32'd4, 32'd4);
    wait_done(n);
    chk("fresh_lat", 64'(n), 64'd33);
    chk("fresh_lo", 64'(Lo), 64'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal range 4..64.
REQ-002 SHALL have port Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port Start  input  1  request a multiplication; sampled only in IDLE or DONE.
REQ-005 SHALL have port Signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with Start.
REQ-006 SHALL have port Abort  input  1  cancel the operation in progress.
REQ-007 SHALL have port Multiplicand  input  WIDTH  first operand; captured with Start.
REQ-008 SHALL have port Multiplier  input  WIDTH  second operand; captured with Start.
REQ-009 SHALL have port Hi  output  WIDTH  upper half of the last completed product.
REQ-010 SHALL have port Lo  output  WIDTH  lower half of the last completed product.
REQ-011 SHALL have port Busy  output  1  high in RUN and FIX.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse, high in DONE.

Function
REQ-013 SHALL implement the states IDLE, RUN, FIX and DONE.
REQ-014 SHALL, in IDLE or DONE with Start=1: latch the operand magnitudes, the result sign (Signed & (msb A ^ msb B)), clear the accumulator and counter, and go to RUN.
REQ-015 SHALL form operand magnitudes as two's-complement negation when Signed=1 and the msb is 1; -2^(WIDTH-1) SHALL give magnitude 2^(WIDTH-1) with no overflow.
REQ-016 SHALL, in RUN, perform one shift-add iteration per cycle for exactly WIDTH cycles: add the multiplicand magnitude to the upper half if the product lsb is 1, keep the carry in a WIDTH+1-bit upper sum, then shift right by one.
REQ-017 SHALL go from RUN to FIX when the counter reaches WIDTH-1 on an iteration edge.
REQ-018 SHALL, in FIX, negate the 2*WIDTH-bit magnitude if the sign is 1, write {Hi,Lo}, and go to DONE.
REQ-019 SHALL, in DONE, assert Done for one cycle and go to IDLE unless Start=1, in which case a new operation is accepted (back-to-back).
REQ-020 SHALL give a latency of WIDTH+2 rising edges from the edge that samples Start to the edge that ends Done.
REQ-021 SHALL give Done high for exactly one cycle, beginning WIDTH+1 edges after Start is sampled.
REQ-022 SHALL change Hi and Lo only on the FIX edge; they hold the previous result during RUN, after Abort, and in IDLE.
REQ-023 SHALL ignore Start in RUN and FIX; the operands in flight are not disturbed.
REQ-024 SHALL treat Abort=1 in RUN or FIX as a return to IDLE on the next edge: no Done, and Hi/Lo unchanged.
REQ-025 SHALL ignore Abort in IDLE and DONE; Abort takes priority over iteration.
REQ-026 SHALL treat Signed=0 with operands having msb set as magnitudes (no sign handling).

Reset
REQ-027 SHALL, while Reset=0: state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, accumulator=0, regardless of Clock.
REQ-028 SHALL treat Reset mid-operation as discarding the operation; after release the block idles until a new Start.

Structure
REQ-029 SHALL take the state encoding (IDLE=0, RUN=1, FIX=2, DONE=3) and the counter-width function (clog2 of WIDTH) from a shared package, mult_pkg.
REQ-030 SHALL place the conditional two's-complement negate (magnitude in, sign in, negated out) in one sub-module, neg_cond, parametrised by width and instantiated for both operands and the product.

Verification (WIDTH=32)
REQ-031 SHALL cover: Signed=0, 7 x 6 -> Hi=0, Lo=0x0000002A, with Done exactly 33 edges after Start.
REQ-032 SHALL cover: Signed=1, -3 x 5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Signed=1, 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0.
REQ-033 SHALL cover: Signed=0, 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; the same operands with Signed=1 -> Hi=0, Lo=1.
REQ-034 SHALL cover: a Start with 9 x 9 pulsed during RUN of 2 x 3 -> result 6; then a back-to-back Start in DONE with 9 x 9 -> 81 with no idle cycle.
REQ-035 SHALL cover: Abort at iteration 10 after a previous result of 42 -> no Done, Hi/Lo stay 0/42, Busy drops on the next edge.
REQ-036 SHALL cover: Reset=0 at iteration 20 -> Hi=Lo=0, Busy=0, no Done; a fresh 4 x 4 after release -> 16.
